// File: rtl/pcie_wr_burst_bridge.sv
// Avalon-MM write bridge: buffers single-beat writes from the DMA ring and merges an
// aligned, contiguous 32B pair into one 2-beat burst toward the PCIe Hard IP TX slave.
module pcie_wr_burst_bridge #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int MERGE_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_address,
    input  logic [DATA_WIDTH-1:0]   s_writedata,
    input  logic [DATA_WIDTH/8-1:0] s_byteenable,
    input  logic                    s_write,
    output logic                    s_waitrequest,
    output logic [ADDR_WIDTH-1:0]   m_address,
    output logic [DATA_WIDTH-1:0]   m_writedata,
    output logic [DATA_WIDTH/8-1:0] m_byteenable,
    output logic [1:0]              m_burstcount,
    output logic                    m_write,
    input  logic                    m_waitrequest,
    output logic                    status_idle,
    output logic [31:0]             stat_merged,
    output logic [31:0]             stat_single,
    output logic [31:0]             stat_timeout
);
    localparam int BEW = DATA_WIDTH / 8;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int TW  = (MERGE_WAIT > 0) ? $clog2(MERGE_WAIT + 1) : 1;
    localparam logic [TW-1:0] TMR_LAST = (MERGE_WAIT > 0) ? TW'(MERGE_WAIT - 1) : '0;
    localparam bit HOLD_EN = (MERGE_WAIT > 0);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_BEAT0, ST_BEAT1} state_t;

    logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [BEW-1:0]        r_fifo_be   [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [TW-1:0]         r_timer;
    state_t                r_state, w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_m_address;
    logic [DATA_WIDTH-1:0] r_m_writedata;
    logic [BEW-1:0]        r_m_byteenable;
    logic [1:0]            r_m_burstcount;
    logic                  r_m_write;
    logic [31:0]           r_stat_merged, r_stat_single, r_stat_timeout;

    logic                  w_full, w_push, w_pop;
    logic [PW-1:0]         w_rd_ptr1;
    logic                  w_head_elig, w_pair;
    logic                  w_ld_single, w_ld_burst2, w_ld_beat1, w_done;
    logic                  w_inc_single, w_inc_merged, w_inc_timeout, w_tmr_clr;

    // Full is taken from the registered level, so a same-cycle pop never opens the slot early.
    assign w_full        = (r_level == LW'(FIFO_DEPTH));
    assign w_push        = s_write && !w_full;
    assign s_waitrequest = w_full;
    assign w_rd_ptr1     = r_rd_ptr + PW'(1);

    assign w_head_elig = (r_fifo_addr[r_rd_ptr][5:0] == 6'd0) && (&r_fifo_be[r_rd_ptr]);
    assign w_pair      = w_head_elig && (r_level >= LW'(2))
                      && (r_fifo_addr[w_rd_ptr1] == r_fifo_addr[r_rd_ptr] + ADDR_WIDTH'(32))
                      && (&r_fifo_be[w_rd_ptr1]);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= s_address;
            r_fifo_data[r_wr_ptr] <= s_writedata;
            r_fifo_be[r_wr_ptr]   <= s_byteenable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_ptr1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ld_single   = 1'b0;
        w_ld_burst2   = 1'b0;
        w_ld_beat1    = 1'b0;
        w_done        = 1'b0;
        w_pop         = 1'b0;
        w_inc_single  = 1'b0;
        w_inc_merged  = 1'b0;
        w_inc_timeout = 1'b0;
        w_tmr_clr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_level != '0) begin
                    if (w_pair) begin
                        w_ld_burst2 = 1'b1;
                        w_state_nxt = ST_BEAT0;
                    end else if (HOLD_EN && w_head_elig && (r_level == LW'(1))) begin
                        w_tmr_clr   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_ld_single = 1'b1;
                        w_state_nxt = ST_BEAT0;
                    end
                end
            end
            ST_HOLD: begin
                if (r_level >= LW'(2)) begin
                    w_ld_burst2 = w_pair;
                    w_ld_single = !w_pair;
                    w_state_nxt = ST_BEAT0;
                end else if (r_timer == TMR_LAST) begin
                    w_ld_single   = 1'b1;
                    w_inc_timeout = 1'b1;
                    w_state_nxt   = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (!m_waitrequest) begin
                    w_pop = 1'b1;
                    if (r_m_burstcount == 2'd2) begin
                        w_ld_beat1  = 1'b1;
                        w_state_nxt = ST_BEAT1;
                    end else begin
                        w_done       = 1'b1;
                        w_inc_single = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end
            ST_BEAT1: begin
                if (!m_waitrequest) begin
                    w_pop        = 1'b1;
                    w_done       = 1'b1;
                    w_inc_merged = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_timer <= '0;
        else if (w_tmr_clr)      r_timer <= '0;
        else if (r_state == ST_HOLD) r_timer <= r_timer + TW'(1);
    end

    // Beat 1 reuses the burst start address; only data and byte enables advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_address    <= '0;
            r_m_writedata  <= '0;
            r_m_byteenable <= '0;
            r_m_burstcount <= '0;
            r_m_write      <= 1'b0;
        end else if (w_ld_single || w_ld_burst2) begin
            r_m_address    <= r_fifo_addr[r_rd_ptr];
            r_m_writedata  <= r_fifo_data[r_rd_ptr];
            r_m_byteenable <= r_fifo_be[r_rd_ptr];
            r_m_burstcount <= w_ld_burst2 ? 2'd2 : 2'd1;
            r_m_write      <= 1'b1;
        end else if (w_ld_beat1) begin
            r_m_writedata  <= r_fifo_data[w_rd_ptr1];
            r_m_byteenable <= r_fifo_be[w_rd_ptr1];
        end else if (w_done) begin
            r_m_write      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_merged  <= '0;
            r_stat_single  <= '0;
            r_stat_timeout <= '0;
        end else begin
            if (w_inc_merged)  r_stat_merged  <= r_stat_merged + 32'd1;
            if (w_inc_single)  r_stat_single  <= r_stat_single + 32'd1;
            if (w_inc_timeout) r_stat_timeout <= r_stat_timeout + 32'd1;
        end
    end

    assign m_address    = r_m_address;
    assign m_writedata  = r_m_writedata;
    assign m_byteenable = r_m_byteenable;
    assign m_burstcount = r_m_burstcount;
    assign m_write      = r_m_write;
    assign status_idle  = (r_level == '0) && (r_state == ST_IDLE);
    assign stat_merged  = r_stat_merged;
    assign stat_single  = r_stat_single;
    assign stat_timeout = r_stat_timeout;

endmodule

// File: tb/tb_pcie_wr_burst_bridge.sv
// Bench for pcie_wr_burst_bridge: directed cases plus random streams checked against
// a transaction-level greedy pairing model of the accepted write stream.
module tb_pcie_wr_burst_bridge;
    localparam int AW = 64;
    localparam int DW = 256;
    localparam int BW = DW / 8;

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic [BW-1:0] be; } item_t;
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic [BW-1:0] be; logic [1:0] bc; } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] s_address = '0;
    logic [DW-1:0] s_writedata = '0;
    logic [BW-1:0] s_byteenable = '0;
    logic          s_write = 1'b0;
    logic          s_waitrequest;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_writedata;
    logic [BW-1:0] m_byteenable;
    logic [1:0]    m_burstcount;
    logic          m_write;
    logic          m_waitrequest;
    logic          status_idle;
    logic [31:0]   stat_merged, stat_single, stat_timeout;

    logic wr_force = 1'b0;
    logic rand_wr = 1'b0;
    logic r_rand_wr = 1'b0;
    assign m_waitrequest = rand_wr ? r_rand_wr : wr_force;

    int total = 0;
    int bad = 0;
    int viol = 0;
    int obs_base = 0;
    item_t in_q[$];
    beat_t obs_q[$];
    beat_t exp_q[$];
    int em, es, et;

    always #5 clk = ~clk;

    pcie_wr_burst_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(8), .MERGE_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_write(s_write), .s_waitrequest(s_waitrequest),
        .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_burstcount(m_burstcount), .m_write(m_write), .m_waitrequest(m_waitrequest),
        .status_idle(status_idle), .stat_merged(stat_merged), .stat_single(stat_single),
        .stat_timeout(stat_timeout)
    );

    always begin
        @(posedge clk);
        #1;
        r_rand_wr = ($urandom_range(0, 2) == 0);
    end

    // Downstream monitor: logs accepted beats and flags any change while stalled.
    beat_t hold_b;
    bit    prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_write || m_address !== hold_b.a || m_writedata !== hold_b.d ||
                               m_byteenable !== hold_b.be || m_burstcount !== hold_b.bc))
                viol++;
            if (m_write && !m_waitrequest)
                obs_q.push_back('{a: m_address, d: m_writedata, be: m_byteenable, bc: m_burstcount});
            prev_stall = m_write && m_waitrequest;
            hold_b = '{a: m_address, d: m_writedata, be: m_byteenable, bc: m_burstcount};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_idle"},  256'(status_idle), 256'(1));
        chk({tag, "_swait"}, 256'(s_waitrequest), 256'(0));
        chk({tag, "_mwr"},   256'(m_write), 256'(0));
        chk({tag, "_maddr"}, 256'(m_address), 256'(0));
        chk({tag, "_mbc"},   256'(m_burstcount), 256'(0));
        chk({tag, "_stats"}, 256'({stat_merged, stat_single, stat_timeout}), 256'(0));
    endtask

    task automatic do_reset();
        s_write  = 1'b0;
        wr_force = 1'b0;
        rand_wr  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_q.delete();
        obs_base = obs_q.size();
    endtask

    // Offers one write and holds it until accepted; returns just after the accepting edge.
    task automatic push_one(input logic [AW-1:0] a, input logic [BW-1:0] be);
        bit acc;
        item_t it;
        it = '{a: a, d: rnd256(), be: be};
        s_address = it.a; s_writedata = it.d; s_byteenable = it.be; s_write = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = !s_waitrequest;
            @(posedge clk);
            #1;
        end
        s_write = 1'b0;
        if (acc) in_q.push_back(it);
        else     chk("push_timeout", 256'(0), 256'(1));
    endtask

    task automatic wait_mwrite(output int k);
        k = -1;
        for (int i = 0; i < 50 && k < 0; i++) begin
            @(negedge clk);
            if (m_write) k = i;
        end
    endtask

    // Greedy left-to-right pairing over a continuously offered stream; an eligible
    // last entry has no follower and therefore waits out the merge window.
    task automatic build_model();
        int i, n;
        bit elig;
        exp_q.delete();
        em = 0; es = 0; et = 0;
        n = in_q.size();
        i = 0;
        while (i < n) begin
            elig = (in_q[i].a % 64 == 0) && (in_q[i].be == {BW{1'b1}});
            if (elig && i + 1 < n && in_q[i+1].a == in_q[i].a + 64'd32 && in_q[i+1].be == {BW{1'b1}}) begin
                exp_q.push_back('{a: in_q[i].a, d: in_q[i].d,   be: in_q[i].be,   bc: 2'd2});
                exp_q.push_back('{a: in_q[i].a, d: in_q[i+1].d, be: in_q[i+1].be, bc: 2'd2});
                em++;
                i += 2;
            end else begin
                exp_q.push_back('{a: in_q[i].a, d: in_q[i].d, be: in_q[i].be, bc: 2'd1});
                es++;
                if (elig && i == n - 1) et++;
                i++;
            end
        end
    endtask

    task automatic check_stream(input string tag);
        bit idle;
        int n;
        beat_t o, e;
        idle = 1'b0;
        for (int k = 0; k < 2000 && !idle; k++) begin
            @(negedge clk);
            idle = status_idle;
        end
        chk({tag, "_drain"}, 256'(idle), 256'(1));
        build_model();
        n = obs_q.size() - obs_base;
        chk({tag, "_nbeats"}, 256'(n), 256'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            o = obs_q[obs_base + i];
            e = exp_q[i];
            chk($sformatf("%s_b%0d_addr", tag, i), 256'(o.a), 256'(e.a));
            chk($sformatf("%s_b%0d_data", tag, i), o.d, e.d);
            chk($sformatf("%s_b%0d_be", tag, i), 256'(o.be), 256'(e.be));
            chk($sformatf("%s_b%0d_bc", tag, i), 256'(o.bc), 256'(e.bc));
        end
        chk({tag, "_merged"},  256'(stat_merged),  256'(em));
        chk({tag, "_single"},  256'(stat_single),  256'(es));
        chk({tag, "_timeout"}, 256'(stat_timeout), 256'(et));
    endtask

    initial begin
        int k, acc_cnt, nitems;
        logic [AW-1:0] base;
        logic [BW-1:0] pbe;

        // Reset state while rst_n is still low.
        @(negedge clk);
        chk_reset_state("rst");

        // 1: aligned contiguous pair merges into one 2-beat burst.
        do_reset();
        push_one(64'h1000, {BW{1'b1}});
        push_one(64'h1020, {BW{1'b1}});
        wait_mwrite(k);
        chk("t1_lat", 256'(k), 256'(1));
        chk("t1_bc", 256'(m_burstcount), 256'(2));
        check_stream("t1");

        // 2: lone eligible write waits out the merge window.
        do_reset();
        push_one(64'h2000, {BW{1'b1}});
        wait_mwrite(k);
        chk("t2_lat", 256'(k), 256'(5));
        chk("t2_bc", 256'(m_burstcount), 256'(1));
        check_stream("t2");

        // 3: upper-half address goes straight out as a single.
        do_reset();
        push_one(64'h2020, {BW{1'b1}});
        wait_mwrite(k);
        chk("t3_lat", 256'(k), 256'(1));
        chk("t3_bc", 256'(m_burstcount), 256'(1));
        check_stream("t3");

        // 4: downstream stalled, FIFO fills at 8 and holds off the 9th write.
        do_reset();
        wr_force = 1'b1;
        for (int i = 0; i < 8; i++) push_one(64'h4000 + 64'(i) * 64'h40, {BW{1'b1}});
        @(negedge clk);
        chk("t4_full", 256'(s_waitrequest), 256'(1));
        s_address = 64'h4200; s_byteenable = {BW{1'b1}}; s_write = 1'b1;
        acc_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (!s_waitrequest) acc_cnt++;
            @(posedge clk);
            #1;
        end
        s_write = 1'b0;
        chk("t4_no_accept", 256'(acc_cnt), 256'(0));
        wr_force = 1'b0;
        push_one(64'h4200, {BW{1'b1}});
        check_stream("t4");

        // 5: non-contiguous follower gives two singles.
        do_reset();
        push_one(64'h1000, {BW{1'b1}});
        push_one(64'h3020, {BW{1'b1}});
        check_stream("t5");

        // 6: reset asserted while the second beat is stalled.
        do_reset();
        wr_force = 1'b1;
        push_one(64'h5000, {BW{1'b1}});
        push_one(64'h5020, {BW{1'b1}});
        wait_mwrite(k);
        chk("t6_beat0", 256'(m_write), 256'(1));
        @(posedge clk); #1;
        wr_force = 1'b0;
        @(posedge clk); #1;
        wr_force = 1'b1;
        @(negedge clk);
        chk("t6_beat1_wr", 256'(m_write), 256'(1));
        chk("t6_beat1_data", m_writedata, in_q[1].d);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", 256'(m_write), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_force = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset_state("t6_post");

        // Random streams with random downstream back-pressure.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            rand_wr = 1'b1;
            nitems = $urandom_range(6, 12);
            for (int j = 0; j < nitems; j++) begin
                base = {$urandom, $urandom} & ~64'h3F;
                pbe = $urandom;
                pbe[$urandom_range(0, BW - 1)] = 1'b0;
                case ($urandom_range(0, 5))
                    0: begin push_one(base, {BW{1'b1}}); push_one(base + 64'd32, {BW{1'b1}}); end
                    1: push_one(base, {BW{1'b1}});
                    2: push_one(base + 64'd32, {BW{1'b1}});
                    3: push_one(base, pbe);
                    4: begin push_one(base, {BW{1'b1}}); push_one(base + 64'd32, pbe); end
                    default: push_one(base + 64'd8, {BW{1'b1}});
                endcase
            end
            check_stream($sformatf("rnd%0d", s));
        end
        rand_wr = 1'b0;

        chk("hold_stable", 256'(viol), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
